// File: rtl/store_pkg.sv
// Shared types and constants for the memory-stage store path.
package store_pkg;

    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_SW  = 2'b00,
        ST_SH  = 2'b01,
        ST_SB  = 2'b10,
        ST_RSV = 2'b11
    } st_op_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
        logic [31:0]       pc;
    } st_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side store/load signals and memory-side write handshake of the store buffer.
interface store_buffer_if #(
    parameter int unsigned AW = 32
);
    logic          st_valid;
    logic [1:0]    st_op;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [31:0]   st_pc;
    logic          st_ready;
    logic          st_err;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hazard;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_pc;
    logic          mem_ack;
    logic          empty;

    modport master (
        output st_valid, st_op, st_addr, st_data, st_pc, ld_valid, ld_addr, mem_ack,
        input  st_ready, st_err, ld_hazard, mem_req, mem_addr, mem_wdata, mem_be, mem_pc, empty
    );

    modport slave (
        input  st_valid, st_op, st_addr, st_data, st_pc, ld_valid, ld_addr, mem_ack,
        output st_ready, st_err, ld_hazard, mem_req, mem_addr, mem_wdata, mem_be, mem_pc, empty
    );

endinterface

// File: rtl/store_lane_align.sv
// Byte-enable and lane-replicated write data for sw/sh/sb; flags misaligned or reserved ops.
module store_lane_align
    import store_pkg::*;
(
    input  st_op_e      op,
    input  logic [1:0]  a,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        aligned
);

    always_comb begin
        be      = '0;
        wdata   = data;
        aligned = 1'b0;
        unique case (op)
            ST_SW: begin
                be      = BE_WORD;
                aligned = (a == 2'b00);
            end
            ST_SH: begin
                be      = a[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata   = {2{data[15:0]}};
                aligned = !a[0];
            end
            ST_SB: begin
                be      = 4'b0001 << a;
                wdata   = {4{data[7:0]}};
                aligned = 1'b1;
            end
            default: begin
                aligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store queue between the M stage and data memory, with load-hit hazard detection.
module store_buffer
    import store_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_q, rd_q;
    logic          err_q;
    st_entry_t     entries_q [DEPTH];
    st_entry_t     head;

    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          aligned;
    logic          push, pop, bad;

    logic [PW-1:0] idx;
    logic [AW-1:0] ent_addr;
    logic [AW-1:0] ld_word;
    logic          hazard;
    logic          unused_ld;

    store_lane_align u_align (
        .op      (st_op_e'(bus.st_op)),
        .a       (bus.st_addr[1:0]),
        .data    (bus.st_data),
        .be      (be),
        .wdata   (wdata),
        .aligned (aligned)
    );

    // A full buffer does not evaluate the store at all, so no error can be raised.
    assign push = bus.st_valid && bus.st_ready && aligned;
    assign bad  = bus.st_valid && bus.st_ready && !aligned;
    assign pop  = bus.mem_req && bus.mem_ack;

    assign bus.st_ready  = (count_q != CW'(DEPTH));
    assign bus.mem_req   = (count_q != '0);
    assign bus.empty     = (count_q == '0);
    assign bus.st_err    = err_q;

    assign head          = entries_q[rd_q];
    assign bus.mem_addr  = AW'(head.addr);
    assign bus.mem_wdata = head.wdata;
    assign bus.mem_be    = head.be;
    assign bus.mem_pc    = head.pc;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= bad;
            if (push) wr_q <= wr_q + PW'(1);
            if (pop)  rd_q <= rd_q + PW'(1);
        end
    end

    // Entry payload needs no reset: only count decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[wr_q] <= '{
                addr:  ADDR_W'({bus.st_addr[AW-1:2], 2'b00}),
                wdata: wdata,
                be:    be,
                pc:    bus.st_pc
            };
        end
    end

    assign ld_word   = {bus.ld_addr[AW-1:2], 2'b00};
    assign unused_ld = ^bus.ld_addr[1:0];

    // Live entries are the count_q slots from rd_q onward; a push this cycle is not yet live.
    always_comb begin
        hazard   = 1'b0;
        idx      = '0;
        ent_addr = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx      = rd_q + PW'(k);
            ent_addr = AW'(entries_q[idx].addr);
            if ((CW'(k) < count_q) && (ent_addr == ld_word)) begin
                hazard = 1'b1;
            end
        end
    end

    assign bus.ld_hazard = bus.ld_valid && hazard;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=2, AW=32).
module tb_store_buffer;
    import store_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    store_buffer_if #(.AW(32)) bus ();

    store_buffer #(
        .DEPTH (2),
        .AW    (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input st_op_e op, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] pc);
        bus.st_valid = 1'b1;
        bus.st_op    = op;
        bus.st_addr  = addr;
        bus.st_data  = data;
        bus.st_pc    = pc;
    endtask

    initial begin
        reset        = 1'b0;
        bus.st_valid = 1'b0;
        bus.st_op    = ST_SW;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_pc    = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.mem_ack  = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        check_eq("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check_eq("rst_empty", 64'(bus.empty), 64'd1);
        check_eq("rst_st_ready", 64'(bus.st_ready), 64'd1);
        check_eq("rst_st_err", 64'(bus.st_err), 64'd0);

        // sb at 0x1003: one-cycle latency, top byte lane
        st(ST_SB, 32'h0000_1003, 32'h1234_56AB, 32'h0000_0400);
        #1;
        check_eq("sb_ready", 64'(bus.st_ready), 64'd1);
        check_eq("sb_no_bypass", 64'(bus.mem_req), 64'd0);
        step();
        bus.st_valid = 1'b0;
        #1;
        check_eq("sb_req", 64'(bus.mem_req), 64'd1);
        check_eq("sb_addr", 64'(bus.mem_addr), 64'h0000_1000);
        check_eq("sb_be", 64'(bus.mem_be), 64'b1000);
        check_eq("sb_wdata", 64'(bus.mem_wdata), 64'hABAB_ABAB);
        check_eq("sb_not_empty", 64'(bus.empty), 64'd0);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        #1;
        check_eq("sb_drained_empty", 64'(bus.empty), 64'd1);
        check_eq("sb_drained_req", 64'(bus.mem_req), 64'd0);

        // sh then sw, drained in order
        st(ST_SH, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0000_0100);
        step();
        st(ST_SW, 32'h0000_2004, 32'hDEAD_BEEF, 32'h0000_0104);
        step();
        bus.st_valid = 1'b0;
        #1;
        check_eq("two_full", 64'(bus.st_ready), 64'd0);
        check_eq("sh_be", 64'(bus.mem_be), 64'b1100);
        check_eq("sh_wdata", 64'(bus.mem_wdata), 64'hBEEF_BEEF);
        check_eq("sh_addr", 64'(bus.mem_addr), 64'h0000_2000);
        check_eq("sh_pc", 64'(bus.mem_pc), 64'h0000_0100);
        step();
        check_eq("sh_hold_be", 64'(bus.mem_be), 64'b1100);
        check_eq("sh_hold_addr", 64'(bus.mem_addr), 64'h0000_2000);
        bus.mem_ack = 1'b1;
        step();
        check_eq("sw_be", 64'(bus.mem_be), 64'b1111);
        check_eq("sw_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
        check_eq("sw_addr", 64'(bus.mem_addr), 64'h0000_2004);
        check_eq("sw_pc", 64'(bus.mem_pc), 64'h0000_0104);
        check_eq("sw_ready_again", 64'(bus.st_ready), 64'd1);
        step();
        bus.mem_ack = 1'b0;
        #1;
        check_eq("pair_empty", 64'(bus.empty), 64'd1);

        // misaligned sw, reserved op, misaligned sh
        st(ST_SW, 32'h0000_0006, 32'hCAFE_0000, 32'h0);
        step();
        bus.st_valid = 1'b0;
        #1;
        check_eq("mis_sw_err", 64'(bus.st_err), 64'd1);
        check_eq("mis_sw_empty", 64'(bus.empty), 64'd1);
        step();
        check_eq("mis_sw_err_clr", 64'(bus.st_err), 64'd0);
        st(ST_RSV, 32'h0000_0010, 32'h1, 32'h0);
        step();
        bus.st_valid = 1'b0;
        #1;
        check_eq("rsv_err", 64'(bus.st_err), 64'd1);
        check_eq("rsv_empty", 64'(bus.empty), 64'd1);
        step();
        check_eq("rsv_err_clr", 64'(bus.st_err), 64'd0);
        st(ST_SH, 32'h0000_7001, 32'h1, 32'h0);
        step();
        bus.st_valid = 1'b0;
        #1;
        check_eq("mis_sh_err", 64'(bus.st_err), 64'd1);
        step();

        // full: push refused while popping, then accepted next cycle
        st(ST_SW, 32'h0000_4000, 32'h1, 32'h0);
        step();
        st(ST_SW, 32'h0000_4004, 32'h2, 32'h0);
        step();
        st(ST_SW, 32'h0000_4008, 32'h3, 32'h0);
        bus.mem_ack = 1'b1;
        #1;
        check_eq("full_refuse", 64'(bus.st_ready), 64'd0);
        check_eq("full_head", 64'(bus.mem_addr), 64'h0000_4000);
        step();
        bus.mem_ack = 1'b0;
        #1;
        check_eq("after_pop_ready", 64'(bus.st_ready), 64'd1);
        check_eq("after_pop_head", 64'(bus.mem_addr), 64'h0000_4004);
        check_eq("full_no_err", 64'(bus.st_err), 64'd0);
        step();
        bus.st_valid = 1'b0;
        #1;
        check_eq("wrap_full", 64'(bus.st_ready), 64'd0);
        check_eq("wrap_head_data", 64'(bus.mem_wdata), 64'h2);
        bus.mem_ack = 1'b1;
        step();
        check_eq("wrap_third_addr", 64'(bus.mem_addr), 64'h0000_4008);
        check_eq("wrap_third_data", 64'(bus.mem_wdata), 64'h3);
        step();
        bus.mem_ack = 1'b0;
        #1;
        check_eq("wrap_empty", 64'(bus.empty), 64'd1);

        // full buffer holds a misaligned store without flagging it
        st(ST_SW, 32'h0000_4100, 32'h4, 32'h0);
        step();
        st(ST_SW, 32'h0000_4104, 32'h5, 32'h0);
        step();
        st(ST_SW, 32'h0000_4102, 32'h6, 32'h0);
        step();
        bus.st_valid = 1'b0;
        #1;
        check_eq("full_mis_no_err", 64'(bus.st_err), 64'd0);
        check_eq("full_mis_head", 64'(bus.mem_addr), 64'h0000_4100);
        bus.mem_ack = 1'b1;
        step();
        step();
        bus.mem_ack = 1'b0;
        #1;
        check_eq("full_mis_empty", 64'(bus.empty), 64'd1);

        // load hazard
        st(ST_SW, 32'h0000_3000, 32'h7, 32'h0);
        step();
        bus.st_valid = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h0000_3002;
        #1;
        check_eq("hz_same_word", 64'(bus.ld_hazard), 64'd1);
        bus.ld_addr = 32'h0000_3004;
        #1;
        check_eq("hz_next_word", 64'(bus.ld_hazard), 64'd0);
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 32'h0000_3000;
        #1;
        check_eq("hz_no_load", 64'(bus.ld_hazard), 64'd0);
        bus.ld_valid = 1'b1;
        bus.mem_ack  = 1'b1;
        #1;
        check_eq("hz_popping", 64'(bus.ld_hazard), 64'd1);
        step();
        bus.mem_ack = 1'b0;
        #1;
        check_eq("hz_after_pop", 64'(bus.ld_hazard), 64'd0);
        st(ST_SW, 32'h0000_5000, 32'h8, 32'h0);
        bus.ld_addr = 32'h0000_5000;
        #1;
        check_eq("hz_pushing", 64'(bus.ld_hazard), 64'd0);
        step();
        bus.st_valid = 1'b0;
        #1;
        check_eq("hz_pushed", 64'(bus.ld_hazard), 64'd1);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack  = 1'b0;
        bus.ld_valid = 1'b0;

        // reset discards pending entries
        st(ST_SW, 32'h0000_6000, 32'h11, 32'h0);
        step();
        st(ST_SW, 32'h0000_6004, 32'h22, 32'h0);
        step();
        st(ST_SW, 32'h0000_6003, 32'h33, 32'h0);
        reset = 1'b0;
        #1;
        check_eq("prerst_req", 64'(bus.mem_req), 64'd1);
        step();
        reset        = 1'b1;
        bus.st_valid = 1'b0;
        #1;
        check_eq("rst2_req", 64'(bus.mem_req), 64'd0);
        check_eq("rst2_empty", 64'(bus.empty), 64'd1);
        check_eq("rst2_err", 64'(bus.st_err), 64'd0);
        check_eq("rst2_ready", 64'(bus.st_ready), 64'd1);
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst2_no_stale", 64'(bus.mem_req), 64'd0);
        end
        bus.mem_ack = 1'b0;

        // lanes after reset
        st(ST_SB, 32'h0000_7001, 32'h0000_0055, 32'h0);
        step();
        bus.st_valid = 1'b0;
        #1;
        check_eq("sb1_be", 64'(bus.mem_be), 64'b0010);
        check_eq("sb1_wdata", 64'(bus.mem_wdata), 64'h5555_5555);
        check_eq("sb1_addr", 64'(bus.mem_addr), 64'h0000_7000);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        st(ST_SH, 32'h0000_7000, 32'h9999_1234, 32'h0);
        step();
        bus.st_valid = 1'b0;
        #1;
        check_eq("shlo_be", 64'(bus.mem_be), 64'b0011);
        check_eq("shlo_wdata", 64'(bus.mem_wdata), 64'h1234_1234);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        #1;
        check_eq("final_empty", 64'(bus.empty), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
